// File: rtl/ram16k_pkg.sv
// Shared definitions for the RAM16K word sequencer: state encoding, byte width,
// parameter defaults and the byte-address construction helper.
package ram16k_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WADDR_W_DEFAULT = 13;
  localparam int unsigned DATA_W_DEFAULT  = 16;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdLo = 3'd1,
    StRdHi = 3'd2,
    StWrLo = 3'd3,
    StWrHi = 3'd4,
    StResp = 3'd5
  } seq_state_e;

  // Byte address = {word address, lane}; the caller truncates to its own width.
  function automatic logic [31:0] byte_addr(input logic [31:0] waddr, input logic lane);
    return {waddr[30:0], lane};
  endfunction

endpackage

// File: rtl/ram_word_sequencer.sv
// Word-access front end for the RAM16K byte store. Each 16-bit request is split into
// two little-endian byte accesses; read bytes are reassembled into a word response.
// Every output is registered: the _d values are computed from the next state.
// Optional build macro RAM_SEQ_BYTE_ENABLE_EN adds cpu_be[1:0] to skip write lanes.
module ram_word_sequencer
  import ram16k_pkg::*;
#(
  parameter int unsigned WADDR_W = WADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [WADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
`ifdef RAM_SEQ_BYTE_ENABLE_EN
  input  logic [1:0]         cpu_be,
`endif
  output logic               cpu_ready,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  input  logic               rsp_ready,
  output logic [WADDR_W:0]   mem_addr,
  output logic               mem_we,
  output logic [BYTE_W-1:0]  mem_wdata,
  input  logic [BYTE_W-1:0]  mem_rdata
);

  localparam int unsigned ADDR_W = WADDR_W + 1;

  seq_state_e state_q, state_d;

  logic               accept;
  logic [WADDR_W-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [1:0]         be_q, be_d;
  logic [BYTE_W-1:0]  lo_q, lo_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;

  logic               cpu_ready_q, cpu_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [BYTE_W-1:0]  mem_wdata_q, mem_wdata_d;

  assign accept = cpu_req && (state_q == StIdle);

  // First write phase for a lane mask; an empty mask acks without touching memory.
  function automatic seq_state_e first_wr_state(input logic [1:0] be);
    if (be[0]) begin
      return StWrLo;
    end else if (be[1]) begin
      return StWrHi;
    end
    return StResp;
  endfunction

  // Request latches and read-byte capture.
  always_comb begin
    addr_d  = accept ? cpu_addr  : addr_q;
    we_d    = accept ? cpu_we    : we_q;
    wdata_d = accept ? cpu_wdata : wdata_q;
`ifdef RAM_SEQ_BYTE_ENABLE_EN
    be_d    = accept ? cpu_be    : be_q;
`else
    be_d    = 2'b11;
`endif
    lo_d    = (state_q == StRdLo) ? mem_rdata : lo_q;
    hi_d    = (state_q == StRdHi) ? mem_rdata : hi_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          state_d = cpu_we ? first_wr_state(be_d) : StRdLo;
        end
      end
      StRdLo: state_d = StRdHi;
      StRdHi: state_d = StResp;
      StWrLo: state_d = be_q[1] ? StWrHi : StResp;
      StWrHi: state_d = StResp;
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-values, decoded from the state being entered.
  always_comb begin
    cpu_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    rsp_data_d  = '0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    if (state_d == StResp && !we_d) begin
      rsp_data_d = {hi_d, lo_d};
    end
    unique case (state_d)
      StRdLo: mem_addr_d = ADDR_W'(byte_addr(32'(addr_d), 1'b0));
      StRdHi: mem_addr_d = ADDR_W'(byte_addr(32'(addr_d), 1'b1));
      StWrLo: begin
        mem_addr_d  = ADDR_W'(byte_addr(32'(addr_d), 1'b0));
        mem_we_d    = 1'b1;
        mem_wdata_d = wdata_d[BYTE_W-1:0];
      end
      StWrHi: begin
        mem_addr_d  = ADDR_W'(byte_addr(32'(addr_d), 1'b1));
        mem_we_d    = 1'b1;
        mem_wdata_d = wdata_d[DATA_W-1:BYTE_W];
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      cpu_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cpu_ready_q <= cpu_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule
